me_pix_feeder: RTL and testbench

ME_PIX_FEEDER -- requirements
Module: me_pix_feeder

---
 rtl/me_pix_feeder_if.sv | 39 +++
 rtl/me_pix_feeder.sv | 115 +++++++++++
 tb/tb_me_pix_feeder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/me_pix_feeder_if.sv
// Feeder control bundle: start/stall in; BRAM read strobes and PE-array sideband out.
// Widths follow the search geometry; registered sideband lags the read strobes by one cycle.
interface me_pix_feeder_if #(
    parameter int PE_Y = 2,
    parameter int SR   = 4
);
    localparam int NX    = SR + 1;
    localparam int WIN_H = PE_Y + SR;
    localparam int RA_W  = $clog2(WIN_H * NX);
    localparam int CA_W  = (PE_Y > 1) ? $clog2(PE_Y) : 1;
    localparam int P_W   = (SR > 0) ? $clog2(SR + 1) : 1;

    logic            start;
    logic            stall;
    logic            ref_rd_en;
    logic [RA_W-1:0] ref_addr;
    logic            curr_rd_en;
    logic [CA_W-1:0] curr_addr;
    logic            pix_valid;
    logic            curr_load;
    logic            sel;
    logic            cand_valid;
    logic [P_W-1:0]  cand_x;
    logic [P_W-1:0]  cand_y;
    logic            busy;
    logic            done;

    modport master (
        input  start, stall,
        output ref_rd_en, ref_addr, curr_rd_en, curr_addr, pix_valid, curr_load,
               sel, cand_valid, cand_x, cand_y, busy, done
    );

    modport slave (
        output start, stall,
        input  ref_rd_en, ref_addr, curr_rd_en, curr_addr, pix_valid, curr_load,
               sel, cand_valid, cand_x, cand_y, busy, done
    );
endinterface

// File: rtl/me_pix_feeder.sv
// Snake-order search-window scanner: one ref read per cycle, array sideband 1 cycle later.
// Stall suppresses the read and freezes the scan position; start is ignored while busy.
module me_pix_feeder #(
    parameter int PIX_WIDTH = 8,
    parameter int PE_X      = 2,
    parameter int PE_Y      = 2,
    parameter int SR        = 4
) (
    input  logic             clk,
    input  logic             rst,
    me_pix_feeder_if.master  bus
);
    localparam int NX    = SR + 1;
    localparam int WIN_H = PE_Y + SR;
    localparam int RA_W  = $clog2(WIN_H * NX);
    localparam int CA_W  = (PE_Y > 1) ? $clog2(PE_Y) : 1;
    localparam int P_W   = (SR > 0) ? $clog2(SR + 1) : 1;
    localparam int KW    = (WIN_H > 1) ? $clog2(WIN_H) : 1;

    if (PIX_WIDTH < 1 || PE_X < 1 || PE_Y < 1) begin : g_bad_geometry
        $error("me_pix_feeder: PIX_WIDTH, PE_X and PE_Y must be positive");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [P_W-1:0]  x_q, x_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   row;
    logic            rd, crd, is_cand, last_k, last_x;
    logic [RA_W-1:0] addr_c;
    logic [CA_W-1:0] caddr_c;
    logic [P_W-1:0]  cy_c;

    logic            pix_valid_q, curr_load_q, sel_q, cand_valid_q;
    logic [P_W-1:0]  cand_x_q, cand_y_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        k_d     = k_q;
        rd      = 1'b0;
        crd     = 1'b0;
        is_cand = 1'b0;
        addr_c  = '0;
        caddr_c = '0;
        cy_c    = '0;
        last_k  = (k_q == KW'(WIN_H - 1));
        last_x  = (x_q == P_W'(NX - 1));
        // odd columns walk the window bottom-up so the array only ever shifts by one row
        row     = x_q[0] ? (KW'(WIN_H - 1) - k_q) : k_q;
        case (state_q)
            IDLE: if (bus.start) state_d = SCAN;
            SCAN: begin
                if (!bus.stall) begin
                    rd      = 1'b1;
                    crd     = (k_q < KW'(PE_Y));
                    addr_c  = RA_W'(row) * RA_W'(NX) + RA_W'(x_q);
                    if (crd)
                        caddr_c = x_q[0] ? (CA_W'(PE_Y - 1) - CA_W'(k_q)) : CA_W'(k_q);
                    is_cand = (k_q >= KW'(PE_Y - 1));
                    if (is_cand)
                        cy_c = x_q[0] ? P_W'(row) : P_W'(k_q - KW'(PE_Y - 1));
                    if (last_k) begin
                        k_d = '0;
                        x_d = last_x ? '0 : x_q + P_W'(1);
                        if (last_x) state_d = DRAIN;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            k_q          <= '0;
            pix_valid_q  <= 1'b0;
            curr_load_q  <= 1'b0;
            sel_q        <= 1'b0;
            cand_valid_q <= 1'b0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            k_q          <= k_d;
            pix_valid_q  <= rd;
            curr_load_q  <= crd;
            sel_q        <= rd & x_q[0];
            cand_valid_q <= is_cand;
            cand_x_q     <= is_cand ? x_q : '0;
            cand_y_q     <= cy_c;
        end
    end

    assign bus.ref_rd_en  = rd;
    assign bus.ref_addr   = addr_c;
    assign bus.curr_rd_en = crd;
    assign bus.curr_addr  = caddr_c;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.curr_load  = curr_load_q;
    assign bus.sel        = sel_q;
    assign bus.cand_valid = cand_valid_q;
    assign bus.cand_x     = cand_x_q;
    assign bus.cand_y     = cand_y_q;
    assign bus.busy       = (state_q == SCAN) || (state_q == DRAIN);
    assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_me_pix_feeder.sv
// Scoreboard bench for me_pix_feeder: driver queues expected reads/sideband/done, monitor checks.
module tb_me_pix_feeder;
    localparam int PE_Y  = 2;
    localparam int SR    = 4;
    localparam int NX    = SR + 1;
    localparam int NY    = SR + 1;
    localparam int WIN_H = PE_Y + SR;
    localparam int NREAD = NX * WIN_H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    me_pix_feeder_if #(.PE_Y(PE_Y), .SR(SR)) bus();

    me_pix_feeder #(.PIX_WIDTH(8), .PE_X(2), .PE_Y(PE_Y), .SR(SR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        int addr;
        bit cen;
        int caddr;
        bit cand;
        int cx;
        int cy;
        bit sel;
    } ev_t;

    ev_t plan[$];
    ev_t rdq[$];
    ev_t pixq[$];
    int  doneq[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  cand_cnt = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Window order: even columns top-down, odd bottom-up; the block is loaded while the
    // first PE_Y rows of a column stream in, and a candidate exists once PE_Y rows are held.
    task automatic build_plan();
        ev_t e;
        plan.delete();
        for (int x = 0; x < NX; x++) begin
            for (int i = 0; i < WIN_H; i++) begin
                int row;
                row    = (x % 2 == 0) ? i : WIN_H - 1 - i;
                e.cyc  = 0;
                e.addr = row * NX + x;
                e.cen  = (i < PE_Y);
                e.caddr = !e.cen ? 0 : ((x % 2 == 0) ? row : row - (WIN_H - PE_Y));
                e.cand = (i >= PE_Y - 1);
                e.cx   = e.cand ? x : 0;
                e.cy   = !e.cand ? 0 : ((x % 2 == 0) ? row - (PE_Y - 1) : row);
                e.sel  = (x % 2 == 1);
                plan.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (bus.ref_rd_en) begin
                if (rdq.size() == 0) chk("unexpected_read", 1, 0);
                else begin
                    e = rdq.pop_front();
                    chk("read_cycle", cyc, e.cyc);
                    chk("ref_addr", int'(bus.ref_addr), e.addr);
                    chk("curr_rd_en", int'(bus.curr_rd_en), int'(e.cen));
                    if (e.cen) chk("curr_addr", int'(bus.curr_addr), e.caddr);
                end
            end else if (bus.curr_rd_en) chk("curr_rd_without_ref", 1, 0);

            if (bus.pix_valid) begin
                if (pixq.size() == 0) chk("unexpected_pix_valid", 1, 0);
                else begin
                    e = pixq.pop_front();
                    chk("pix_cycle", cyc, e.cyc + 1);
                    chk("sel", int'(bus.sel), int'(e.sel));
                    chk("curr_load", int'(bus.curr_load), int'(e.cen));
                    chk("cand_valid", int'(bus.cand_valid), int'(e.cand));
                    if (e.cand) begin
                        chk("cand_x", int'(bus.cand_x), e.cx);
                        chk("cand_y", int'(bus.cand_y), e.cy);
                    end
                end
            end else if (bus.cand_valid || bus.curr_load) chk("sideband_without_pix", 1, 0);

            if (bus.cand_valid) cand_cnt++;

            if (bus.done) begin
                if (doneq.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, doneq.pop_front());
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_ref_rd_en"}, int'(bus.ref_rd_en), 0);
        chk({tag, "_ref_addr"}, int'(bus.ref_addr), 0);
        chk({tag, "_curr_rd_en"}, int'(bus.curr_rd_en), 0);
        chk({tag, "_curr_addr"}, int'(bus.curr_addr), 0);
        chk({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
        chk({tag, "_curr_load"}, int'(bus.curr_load), 0);
        chk({tag, "_cand_valid"}, int'(bus.cand_valid), 0);
        chk({tag, "_cand_xy"}, int'(bus.cand_x) + int'(bus.cand_y), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
    endtask

    // Called just after a rising edge. Stall is chosen per cycle; every unstalled scan
    // cycle issues the next planned read. abort_after>0 returns mid-scan after that many reads.
    task automatic run_scan(input int hold, input bit rnd, input int stall_at,
                            input int stall_len, input int repulse_at, input int abort_after);
        ev_t e;
        int  p, n, issued, scnt, last, base;
        bit  st;
        build_plan();
        base   = cand_cnt;
        p      = cyc;
        issued = 0;
        scnt   = 0;
        last   = -1;
        bus.start = 1'b1;
        bus.stall = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            n = cyc - p;
            if (n == 2) chk("busy_in_scan", int'(bus.busy), 1);
            bus.start = (n < hold) || (n == repulse_at);
            st = 1'b0;
            if (issued < NREAD) begin
                if (rnd) st = ($urandom_range(0, 3) == 0);
                else if (issued == stall_at && scnt < stall_len) begin
                    st = 1'b1;
                    scnt++;
                end
            end
            bus.stall = st;
            if (issued < NREAD && !st) begin
                e = plan[issued];
                e.cyc = cyc;
                rdq.push_back(e);
                pixq.push_back(e);
                issued++;
                if (issued == NREAD) begin
                    doneq.push_back(cyc + 2);
                    last = cyc;
                end
                if (issued == abort_after) return;
            end
            if (last >= 0 && cyc >= last + 5 && n > hold && n > repulse_at) break;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        chk("reads_outstanding", rdq.size(), 0);
        chk("pix_outstanding", pixq.size(), 0);
        chk("done_outstanding", doneq.size(), 0);
        chk("cand_count", cand_cnt - base, NX * NY);
        chk("busy_after_scan", int'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // plain scan, then a 3-cycle stall at x=2 k=3, then held start with a mid-scan re-pulse
        run_scan(1, 1'b0, -1, 0, -1, 0);
        repeat (2) @(posedge clk); #1;
        run_scan(1, 1'b0, 2 * WIN_H + 3, 3, -1, 0);
        repeat (2) @(posedge clk); #1;
        run_scan(4, 1'b0, -1, 0, 15, 0);
        repeat (2) @(posedge clk); #1;

        // abort mid-scan with a 2-cycle reset; start held during the reset must be ignored
        run_scan(1, 1'b0, -1, 0, -1, 10);
        rst       = 1'b1;
        mon_en    = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        @(posedge clk); #1;
        check_idle("rst_first_edge");
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check_idle("rst_over_start");
        rdq.delete();
        pixq.delete();
        doneq.delete();
        mon_en = 1'b1;
        @(posedge clk); #1;
        check_idle("after_reset");
        run_scan(1, 1'b0, -1, 0, -1, 0);

        for (int r = 0; r < 3; r++) begin
            repeat (1 + r) @(posedge clk); #1;
            run_scan(1 + r, 1'b1, -1, 0, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
